// File: rtl/f2c_dma_sched_if.sv
// Handshake bundle between the F2C DMA scheduler, its source FIFO and the TLP transmitter.
// master = scheduler side, slave = FIFO/transmitter side.
interface f2c_dma_sched_if #(
    parameter int QW_BITS    = 4,
    parameter int ADDR_WIDTH = 32
);
    // F2C FIFO head and occupancy
    logic [QW_BITS:0]    f2c_count;
    logic [63:0]         f2c_data;
    logic                f2c_valid;
    logic                f2c_ready;

    // MWr header request
    logic                cmd_valid;
    logic                cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [QW_BITS:0]    cmd_len;

    // MWr payload stream
    logic [63:0]         tx_data;
    logic                tx_valid;
    logic                tx_ready;

    modport master (
        input  f2c_count, f2c_data, f2c_valid, cmd_ready, tx_ready,
        output f2c_ready, cmd_valid, cmd_addr, cmd_len, tx_data, tx_valid
    );

    modport slave (
        output f2c_count, f2c_data, f2c_valid, cmd_ready, tx_ready,
        input  f2c_ready, cmd_valid, cmd_addr, cmd_len, tx_data, tx_valid
    );
endinterface

// File: rtl/f2c_dma_sched.sv
// FPGA->CPU DMA ring sequencer: data MWr of one full TLP into slot wr_ptr, then a metrics MWr of wr_ptr.
// Optional ring-full stall counter enabled by defining F2C_STALL_CNT_EN.
module f2c_dma_sched #(
    parameter int SLOT_BITS  = 4,
    parameter int QW_BITS    = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  pcie_clk,
    input  logic                  pcie_rst_n,
    input  logic                  dma_enable,
    input  logic [ADDR_WIDTH-1:0] f2c_base,
    input  logic [ADDR_WIDTH-1:0] mtr_base,
    input  logic [SLOT_BITS-1:0]  rd_ptr,
    f2c_dma_sched_if.master       bus,
    output logic [SLOT_BITS-1:0]  wr_ptr,
    output logic                  busy,
    output logic [31:0]           stall_count
);

    localparam logic [QW_BITS:0] DATA_LEN = {1'b1, {QW_BITS{1'b0}}};
    localparam logic [QW_BITS:0] MTR_LEN  = {{QW_BITS{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA_HDR,
        ST_DATA_PAY,
        ST_MTR_HDR,
        ST_MTR_PAY
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [QW_BITS-1:0]    beat_cnt;

    logic                  ring_full;
    logic                  tlp_ready;
    logic                  start;
    logic                  beat_xfer;
    logic                  last_beat;

    // Full uses the live host pointer so a same-cycle F2C_RDPTR write frees the slot at once.
    assign ring_full = (wr_ptr + SLOT_BITS'(1)) == rd_ptr;
    assign tlp_ready = bus.f2c_count == DATA_LEN;
    assign start     = dma_enable && !ring_full && tlp_ready;
    assign beat_xfer = bus.f2c_valid && bus.tx_ready;
    assign last_beat = beat_cnt == '1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus.f2c_ready = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DATA_HDR;
                end
            end
            ST_DATA_HDR: begin
                bus.cmd_valid = 1'b1;
                bus.cmd_addr  = d_addr;
                bus.cmd_len   = DATA_LEN;
                if (bus.cmd_ready) begin
                    state_d = ST_DATA_PAY;
                end
            end
            ST_DATA_PAY: begin
                bus.tx_valid  = bus.f2c_valid;
                bus.tx_data   = bus.f2c_data;
                bus.f2c_ready = bus.tx_ready;
                if (beat_xfer && last_beat) begin
                    state_d = ST_MTR_HDR;
                end
            end
            ST_MTR_HDR: begin
                bus.cmd_valid = 1'b1;
                bus.cmd_addr  = m_addr;
                bus.cmd_len   = MTR_LEN;
                if (bus.cmd_ready) begin
                    state_d = ST_MTR_PAY;
                end
            end
            ST_MTR_PAY: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = 64'(wr_ptr);
                if (bus.tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Addresses are captured at launch so register writes cannot disturb a transfer in flight.
    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            wr_ptr   <= '0;
            d_addr   <= '0;
            m_addr   <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            busy <= (state_d != ST_IDLE);
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        d_addr   <= f2c_base + (ADDR_WIDTH'(wr_ptr) << QW_BITS);
                        m_addr   <= mtr_base;
                        beat_cnt <= '0;
                    end else if (!dma_enable) begin
                        wr_ptr <= '0;
                    end
                end
                ST_DATA_PAY: begin
                    if (beat_xfer) begin
                        beat_cnt <= beat_cnt + QW_BITS'(1);
                        if (last_beat) begin
                            wr_ptr <= wr_ptr + SLOT_BITS'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef F2C_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            stall_cnt <= '0;
        end else if (!dma_enable) begin
            stall_cnt <= '0;
        end else if ((state_q == ST_IDLE) && ring_full && tlp_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_count = stall_cnt;
`else
    assign stall_count = '0;
`endif

    // A stalled header must not change under the transmitter.
    hdr_stable_a : assert property (
        @(posedge pcie_clk) disable iff (!pcie_rst_n)
        (bus.cmd_valid && !bus.cmd_ready) |=>
            (bus.cmd_valid && $stable(bus.cmd_addr) && $stable(bus.cmd_len))
    );

endmodule
